// File: rtl/dmem_arb_pkg.sv
// Shared constants and types for the dmem CPU/host arbiter.
package dmem_arb_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 16;
  localparam int unsigned STARVE_W   = 8;

  // Bench "finish" mailbox: byte address on the bus and its word address
  localparam logic [31:0] FINISH_BADDR = 32'h0000_7fff;
  localparam logic [15:0] FINISH_WADDR = FINISH_BADDR[17:2];

  typedef enum logic {
    GSRC_CPU = 1'b0,
    GSRC_HST = 1'b1
  } gsrc_e;

endpackage

// File: rtl/dmem_arb_if.sv
// CPU, host and memory-side signal bundle for the dmem arbiter.
interface dmem_arb_if
  import dmem_arb_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
);

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;

  logic              hst_req;
  logic              hst_we;
  logic [ADDR_W-1:0] hst_addr;
  logic [DATA_W-1:0] hst_wdata;
  logic              hst_gnt;
  logic [DATA_W-1:0] hst_rdata;
  logic              hst_rvalid;

  logic [ADDR_W-1:0] mem_a;
  logic [DATA_W-1:0] mem_wd;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rd;

  // Requesters and memory side
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output hst_req, hst_we, hst_addr, hst_wdata,
    output mem_rd,
    input  cpu_rdata, cpu_stall,
    input  hst_gnt, hst_rdata, hst_rvalid,
    input  mem_a, mem_wd, mem_we
  );

  // Arbiter side
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  hst_req, hst_we, hst_addr, hst_wdata,
    input  mem_rd,
    output cpu_rdata, cpu_stall,
    output hst_gnt, hst_rdata, hst_rvalid,
    output mem_a, mem_wd, mem_we
  );

endinterface

// File: rtl/dmem_arb_starve.sv
// Host starvation tracker: raises a one-cycle forced-host-slot flag after
// STARVE_MAX consecutive denied host-request cycles.
module dmem_arb_starve
  import dmem_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i_hst_req,
  input  logic i_hst_gnt,
  output logic o_force
);

  logic [STARVE_W-1:0] r_cnt;
  logic [STARVE_W-1:0] w_cnt_nxt;
  logic                r_force;
  logic                w_force_nxt;
  logic                w_denied;

  assign w_denied = i_hst_req & ~i_hst_gnt;

  // Any grant or idle host cycle clears both counter and flag
  always_comb begin
    w_cnt_nxt   = '0;
    w_force_nxt = 1'b0;
    if (w_denied) begin
      w_cnt_nxt   = (&r_cnt) ? r_cnt : r_cnt + STARVE_W'(1);
      w_force_nxt = (r_cnt == STARVE_W'(STARVE_MAX - 1));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_force <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_force <= w_force_nxt;
    end
  end

  assign o_force = r_force;

endmodule

// File: rtl/dmem_arb.sv
// Two-requester dmem arbiter: CPU has priority, host gets a forced slot when
// starved. Optional statistics counters are built with DMEM_ARB_STAT_EN.
module dmem_arb
  import dmem_arb_pkg::*;
#(
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic       clk,
  input  logic       rst,
  dmem_arb_if.slave  bus
`ifdef DMEM_ARB_STAT_EN
  ,
  output logic [31:0] stat_stall,
  output logic [31:0] stat_hgnt
`endif
);

  logic              w_force;
  logic              w_gnt;
  logic              w_stall;
  gsrc_e             w_gsrc;
  logic [ADDR_W-1:0] w_mem_a;
  logic [DATA_W-1:0] w_mem_wd;
  logic              w_mem_we;
  logic              r_rvalid;
  logic [DATA_W-1:0] r_rdata;

  dmem_arb_starve #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve (
    .clk       (clk),
    .rst       (rst),
    .i_hst_req (bus.hst_req),
    .i_hst_gnt (w_gnt),
    .o_force   (w_force)
  );

  assign w_gnt   = ~rst & bus.hst_req & (~bus.cpu_req | w_force);
  assign w_stall = ~rst & bus.cpu_req & w_gnt;
  assign w_gsrc  = w_gnt ? GSRC_HST : GSRC_CPU;

  // Memory port steering
  always_comb begin
    w_mem_a  = bus.cpu_addr;
    w_mem_wd = bus.cpu_wdata;
    w_mem_we = bus.cpu_req & bus.cpu_we & ~rst;
    if (w_gsrc == GSRC_HST) begin
      w_mem_a  = bus.hst_addr;
      w_mem_wd = bus.hst_wdata;
      w_mem_we = bus.hst_we;
    end
  end

  // Host read data is captured at the edge closing the granted cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_rvalid <= w_gnt & ~bus.hst_we;
      if (w_gnt & ~bus.hst_we) begin
        r_rdata <= bus.mem_rd;
      end
    end
  end

  assign bus.mem_a      = w_mem_a;
  assign bus.mem_wd     = w_mem_wd;
  assign bus.mem_we     = w_mem_we;
  assign bus.cpu_rdata  = bus.mem_rd;
  assign bus.cpu_stall  = w_stall;
  assign bus.hst_gnt    = w_gnt;
  assign bus.hst_rdata  = r_rdata;
  assign bus.hst_rvalid = r_rvalid;

`ifdef DMEM_ARB_STAT_EN
  logic [31:0] r_stat_stall;
  logic [31:0] r_stat_hgnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stat_stall <= '0;
      r_stat_hgnt  <= '0;
    end else begin
      if (w_stall && !(&r_stat_stall)) r_stat_stall <= r_stat_stall + 32'd1;
      if (w_gnt && !(&r_stat_hgnt))    r_stat_hgnt  <= r_stat_hgnt + 32'd1;
    end
  end

  assign stat_stall = r_stat_stall;
  assign stat_hgnt  = r_stat_hgnt;
`endif

endmodule

// File: tb/tb_dmem_arb.sv
// Self-checking bench for dmem_arb: vector table, directed corner sequences
// and randomized traffic against a starvation-window reference model.
module tb_dmem_arb;
  import dmem_arb_pkg::*;

  localparam int unsigned SMAX = 8;
  localparam int unsigned DW   = 32;
  localparam int unsigned AW   = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dmem_arb_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

`ifdef DMEM_ARB_STAT_EN
  logic [31:0] stat_stall;
  logic [31:0] stat_hgnt;
`endif

  dmem_arb #(.DATA_W(DW), .ADDR_W(AW), .STARVE_MAX(SMAX)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus)
`ifdef DMEM_ARB_STAT_EN
    ,
    .stat_stall (stat_stall),
    .stat_hgnt  (stat_hgnt)
`endif
  );

  // Physical memory: asynchronous read, synchronous write
  logic [31:0] mem [0:1023];
  assign bus.mem_rd = mem[bus.mem_a[9:0]];
  always @(posedge clk) if (bus.mem_we) mem[bus.mem_a[9:0]] <= bus.mem_wd;

  // Reference model state
  logic [31:0] exp_mem [0:1023];
  int          m_denied;
  logic        m_rv;
  logic [31:0] m_rdata;

  // DUT samples of the latest cycle
  logic        s_gnt, s_stall, s_we, s_rv;
  logic [15:0] s_a;
  logic [31:0] s_wd, s_rdata, s_crd;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic        creq, cwe;
    logic [15:0] caddr;
    logic [31:0] cwd;
    logic        hreq, hwe;
    logic [15:0] haddr;
    logic [31:0] hwd;
    logic        e_gnt, e_stall, e_we;
    logic [15:0] e_a;
    logic        e_rv;
    logic [31:0] e_rd;
  } vec_t;

  vec_t tbl [12];

  function automatic logic [31:0] pat(input int i);
    return {16'hc0de, 16'(i)};
  endfunction

  function automatic vec_t mk(input bit creq, input bit cwe, input int caddr, input logic [31:0] cwd,
                              input bit hreq, input bit hwe, input int haddr, input logic [31:0] hwd,
                              input bit eg, input bit es, input bit ew, input int ea,
                              input bit erv, input logic [31:0] erd);
    vec_t v;
    v.creq = creq; v.cwe = cwe; v.caddr = 16'(caddr); v.cwd = cwd;
    v.hreq = hreq; v.hwe = hwe; v.haddr = 16'(haddr); v.hwd = hwd;
    v.e_gnt = eg; v.e_stall = es; v.e_we = ew; v.e_a = 16'(ea);
    v.e_rv = erv; v.e_rd = erd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_denied = 0;
    m_rv     = 1'b0;
    m_rdata  = '0;
  endtask

  // One clock cycle, entered at posedge+1, left at next posedge+1
  task automatic cycle(input logic creq, input logic cwe, input logic [15:0] caddr, input logic [31:0] cwd,
                       input logic hreq, input logic hwe, input logic [15:0] haddr, input logic [31:0] hwd,
                       output logic gnt);
    logic        m_gnt, m_stall, m_we;
    logic [15:0] m_a;
    logic [31:0] m_wd;
    bus.cpu_req = creq; bus.cpu_we = cwe; bus.cpu_addr = caddr; bus.cpu_wdata = cwd;
    bus.hst_req = hreq; bus.hst_we = hwe; bus.hst_addr = haddr; bus.hst_wdata = hwd;
    #4;
    // Host wins when CPU is idle or after SMAX consecutive denials
    m_gnt   = hreq && (!creq || m_denied == int'(SMAX));
    m_stall = creq && m_gnt;
    if (m_gnt) begin m_we = hwe; m_a = haddr; m_wd = hwd; end
    else begin m_we = creq && cwe; m_a = caddr; m_wd = cwd; end
    s_gnt = bus.hst_gnt; s_stall = bus.cpu_stall; s_we = bus.mem_we; s_a = bus.mem_a;
    s_wd = bus.mem_wd; s_rv = bus.hst_rvalid; s_rdata = bus.hst_rdata; s_crd = bus.cpu_rdata;
    chk("m_gnt", 32'(s_gnt), 32'(m_gnt));
    chk("m_stall", 32'(s_stall), 32'(m_stall));
    chk("m_mem_we", 32'(s_we), 32'(m_we));
    chk("m_mem_a", 32'(s_a), 32'(m_a));
    if (m_we) chk("m_mem_wd", s_wd, m_wd);
    chk("m_rvalid", 32'(s_rv), 32'(m_rv));
    if (m_rv) chk("m_rdata", s_rdata, m_rdata);
    if (creq && !cwe && !m_stall) chk("m_cpu_rdata", s_crd, exp_mem[caddr[9:0]]);
    gnt = m_gnt;
    @(posedge clk);
    if (hreq && !m_gnt) m_denied++; else m_denied = 0;
    m_rv = m_gnt && !hwe;
    if (m_rv) m_rdata = exp_mem[haddr[9:0]];
    if (m_we) exp_mem[m_a[9:0]] = m_wd;
    #1;
  endtask

  task automatic idle();
    logic g;
    cycle(1'b0, 1'b0, 16'd0, 32'd0, 1'b0, 1'b0, 16'd0, 32'd0, g);
  endtask

  initial begin
    logic        g;
    int          pulses;
    logic        h_act, h_we;
    logic [15:0] h_addr;
    logic [31:0] h_wd;
    logic        c_req, c_we;
`ifdef DMEM_ARB_STAT_EN
    logic [31:0] snap_stall, snap_hgnt;
`endif

    for (int i = 0; i < 1024; i++) begin
      mem[i]     <= pat(i);
      exp_mem[i]  = pat(i);
    end
    model_reset();

    // Reset state, with requests active to show outputs are gated
    rst = 1'b1;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 16'd7; bus.cpu_wdata = 32'h55;
    bus.hst_req = 1'b1; bus.hst_we = 1'b1; bus.hst_addr = 16'd8; bus.hst_wdata = 32'h66;
    #2;
    chk("rst_gnt", 32'(bus.hst_gnt), 32'd0);
    chk("rst_stall", 32'(bus.cpu_stall), 32'd0);
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst_rvalid", 32'(bus.hst_rvalid), 32'd0);
    chk("rst_rdata", bus.hst_rdata, 32'd0);
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.hst_req = 1'b0; bus.hst_we = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Vector table
    tbl[0]  = mk(0,0,0,0,          0,0,0,0,            0,0,0,0,   0,0);
    tbl[1]  = mk(0,0,0,0,          1,1,256,32'hdeadbeef, 1,0,1,256, 0,0);
    tbl[2]  = mk(0,0,0,0,          1,0,256,0,          1,0,0,256, 0,0);
    tbl[3]  = mk(0,0,0,0,          0,0,0,0,            0,0,0,0,   1,32'hdeadbeef);
    tbl[4]  = mk(1,1,10,5,         0,0,0,0,            0,0,1,10,  0,0);
    tbl[5]  = mk(1,0,10,0,         1,0,20,0,           0,0,0,10,  0,0);
    tbl[6]  = mk(1,0,10,0,         0,0,0,0,            0,0,0,10,  0,0);
    tbl[7]  = mk(0,0,0,0,          1,0,20,0,           1,0,0,20,  0,0);
    tbl[8]  = mk(0,0,0,0,          0,0,0,0,            0,0,0,0,   1,pat(20));
    tbl[9]  = mk(1,1,30,7,         1,0,40,0,           0,0,1,30,  0,0);
    tbl[10] = mk(0,0,0,0,          1,0,40,0,           1,0,0,40,  0,0);
    tbl[11] = mk(1,0,30,0,         0,0,0,0,            0,0,0,30,  1,pat(40));
    for (int i = 0; i < 12; i++) begin
      cycle(tbl[i].creq, tbl[i].cwe, tbl[i].caddr, tbl[i].cwd,
            tbl[i].hreq, tbl[i].hwe, tbl[i].haddr, tbl[i].hwd, g);
      chk($sformatf("v%0d_gnt", i), 32'(s_gnt), 32'(tbl[i].e_gnt));
      chk($sformatf("v%0d_stall", i), 32'(s_stall), 32'(tbl[i].e_stall));
      chk($sformatf("v%0d_we", i), 32'(s_we), 32'(tbl[i].e_we));
      chk($sformatf("v%0d_a", i), 32'(s_a), 32'(tbl[i].e_a));
      chk($sformatf("v%0d_rv", i), 32'(s_rv), 32'(tbl[i].e_rv));
      if (tbl[i].e_rv) chk($sformatf("v%0d_rd", i), s_rdata, tbl[i].e_rd);
    end

    // CPU priority: host waits SMAX cycles, then one forced slot
`ifdef DMEM_ARB_STAT_EN
    snap_stall = stat_stall; snap_hgnt = stat_hgnt;
`endif
    for (int k = 1; k <= int'(SMAX) + 1; k++) begin
      cycle(1'b1, 1'b0, 16'd4, 32'd0, 1'b1, 1'b0, 16'd256, 32'd0, g);
      chk($sformatf("prio_gnt_c%0d", k), 32'(s_gnt), (k == int'(SMAX) + 1) ? 32'd1 : 32'd0);
      chk($sformatf("prio_stall_c%0d", k), 32'(s_stall), (k == int'(SMAX) + 1) ? 32'd1 : 32'd0);
    end
    cycle(1'b1, 1'b0, 16'd4, 32'd0, 1'b0, 1'b0, 16'd0, 32'd0, g);
    chk("prio_after_stall", 32'(s_stall), 32'd0);
    chk("prio_rvalid", 32'(s_rv), 32'd1);
    chk("prio_rdata", s_rdata, 32'hdeadbeef);
`ifdef DMEM_ARB_STAT_EN
    chk("stat_stall_delta", stat_stall - snap_stall, 32'd1);
    chk("stat_hgnt_delta", stat_hgnt - snap_hgnt, 32'd1);
`endif
    cycle(1'b1, 1'b0, 16'd4, 32'd0, 1'b1, 1'b0, 16'd256, 32'd0, g);
    chk("prio_cnt_cleared", 32'(s_gnt), 32'd0);
    for (int k = 0; k < 20 && !g; k++)
      cycle(1'b1, 1'b0, 16'd4, 32'd0, 1'b1, 1'b0, 16'd256, 32'd0, g);
    idle();

    // Same-address write collision: host forced write, then CPU retry lands last
    for (int k = 1; k <= int'(SMAX) + 1; k++)
      cycle(1'b1, 1'b1, 16'd300, 32'h1111, 1'b1, 1'b1, 16'd300, 32'h2222, g);
    chk("coll_host_first", mem[300], 32'h2222);
    cycle(1'b1, 1'b1, 16'd300, 32'h1111, 1'b0, 1'b0, 16'd0, 32'd0, g);
    chk("coll_cpu_last", mem[300], 32'h1111);

    // Dump burst 256..1023
    pulses = 0;
    for (int a = 256; a < 1024; a++) begin
      cycle(1'b0, 1'b0, 16'd0, 32'd0, 1'b1, 1'b0, 16'(a), 32'd0, g);
      if (s_rv) pulses++;
    end
    idle();
    if (s_rv) pulses++;
    chk("dump_pulses", 32'(pulses), 32'd768);

    // Reset drops a pending host read response
    cycle(1'b0, 1'b0, 16'd0, 32'd0, 1'b1, 1'b0, 16'd500, 32'd0, g);
    #1;
    chk("rstA_pre_rv", 32'(bus.hst_rvalid), 32'd1);
    rst = 1'b1;
    #1;
    chk("rstA_rv_drop", 32'(bus.hst_rvalid), 32'd0);
    chk("rstA_rdata_clr", bus.hst_rdata, 32'd0);
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.hst_req = 1'b1;
    #1;
    chk("rstA_gnt", 32'(bus.hst_gnt), 32'd0);
    chk("rstA_stall", 32'(bus.cpu_stall), 32'd0);
    chk("rstA_mem_we", 32'(bus.mem_we), 32'd0);
    @(posedge clk); #3;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.hst_req = 1'b0;
    rst = 1'b0;
    model_reset();
    @(posedge clk); #1;

    // Reset during a forced host write slot
    for (int k = 1; k <= int'(SMAX); k++)
      cycle(1'b1, 1'b0, 16'd4, 32'd0, 1'b1, 1'b1, 16'd600, 32'hbeef, g);
    #2;
    chk("rstB_force_gnt", 32'(bus.hst_gnt), 32'd1);
    chk("rstB_force_we", 32'(bus.mem_we), 32'd1);
    rst = 1'b1;
    #1;
    chk("rstB_gnt", 32'(bus.hst_gnt), 32'd0);
    chk("rstB_stall", 32'(bus.cpu_stall), 32'd0);
    chk("rstB_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rstB_rvalid", 32'(bus.hst_rvalid), 32'd0);
    bus.cpu_req = 1'b0; bus.hst_req = 1'b0; bus.hst_we = 1'b0;
    @(posedge clk); #3;
    rst = 1'b0;
    model_reset();
    @(posedge clk); #1;
    cycle(1'b1, 1'b0, 16'd4, 32'd0, 1'b1, 1'b0, 16'd600, 32'd0, g);
    chk("rstB_cpu_first", 32'(s_gnt), 32'd0);
    for (int k = 0; k < 20 && !g; k++)
      cycle(1'b1, 1'b0, 16'd4, 32'd0, 1'b1, 1'b0, 16'd600, 32'd0, g);
    chk("rstB_mem_untouched", mem[600], exp_mem[600]);

    // Randomized traffic, host holds each request until granted
    h_act = 1'b0; h_we = 1'b0; h_addr = '0; h_wd = '0;
    for (int n = 0; n < 1500; n++) begin
      if (!h_act && $urandom_range(0, 2) != 0) begin
        h_act  = 1'b1;
        h_we   = 1'($urandom_range(0, 1));
        h_addr = 16'($urandom_range(0, 63));
        h_wd   = $urandom;
      end
      c_req = ($urandom_range(0, 3) != 0);
      c_we  = 1'($urandom_range(0, 1));
      cycle(c_req, c_we, 16'($urandom_range(0, 63)), $urandom, h_act, h_we, h_addr, h_wd, g);
      if (g) h_act = 1'b0;
    end
    idle();

    // Finish mailbox write on the real port
    cycle(1'b0, 1'b0, 16'd0, 32'd0, 1'b1, 1'b1, FINISH_WADDR, 32'd1, g);
    chk("finish_addr", 32'(s_a), 32'(FINISH_WADDR));
    idle();

    for (int i = 0; i < 1024; i++) begin
      if (mem[i] !== exp_mem[i]) chk($sformatf("mem_%0d", i), mem[i], exp_mem[i]);
      else n_cmp++;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
